// File: rtl/mat_wb_pkg.sv
// mat_wb_pkg: shared types and constants for the matrix result write-back
// stage (mat_result_writeback and its FIFO).
//   ORDER_W      - default width of the matrix order input
//   WORD_BYTES   - bytes per memory word (address stride per element)
//   DATA_W       - default element / memory data width
//   state_t      - write-back controller states
//   fifo_entry_t - FIFO entry layout {addr, data} at the default data width;
//                  the top re-declares the same layout at its own BITWIDTH
package mat_wb_pkg;

    localparam int unsigned ORDER_W    = 10;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mat_wb_fifo.sv
// mat_wb_fifo: synchronous FIFO decoupling element acceptance from memory
// stalls. Head entry is presented combinationally on dout.
//   clk, resetn      - clock, asynchronous active-low reset (empties FIFO)
//   push, din        - write an entry (ignored when full)
//   pop              - drop the head entry (ignored when empty)
//   dout             - head entry
//   full, empty, one - occupancy flags (one: exactly one entry held)
// DEPTH must be a power of two and at least 2.
module mat_wb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             one
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;

    // Pointers carry one extra wrap bit, so level spans 0..DEPTH and its MSB
    // is set only when completely full.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = level[AW];
    assign one   = (level == LEVEL_ONE);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_result_writeback.sv
// mat_result_writeback: accepts row-major result elements of C (n x n) on a
// valid/ready stream and writes each to memory at
// base_addr + 4*(r*order + c) through a valid/ready write port. Pulses done
// once every accepted element has been written; err flags a length mismatch
// between in_last and order*order.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   start, order,base_addr - job launch (honoured only when idle)
//   transpose              - (MAT_WB_TRANSPOSE_EN only) store C^T instead
//   in_valid/in_ready/in_data/in_last - element input stream
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb - memory write port
//   busy, done, err        - status
// Optional feature macro: MAT_WB_TRANSPOSE_EN (adds the transpose port).
module mat_result_writeback #(
    parameter int unsigned BITWIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ORDER_W    = mat_wb_pkg::ORDER_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ORDER_W-1:0]  order,
    input  logic [31:0]         base_addr,
`ifdef MAT_WB_TRANSPOSE_EN
    input  logic                transpose,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic [BITWIDTH-1:0] mem_wdata,
    output logic [3:0]          mem_wstrb,
    output logic                busy,
    output logic                done,
    output logic                err
);

    import mat_wb_pkg::*;

    localparam int unsigned CNT_W = 2 * ORDER_W;

    typedef struct packed {
        logic [31:0]         addr;
        logic [BITWIDTH-1:0] data;
    } entry_t;

    state_t             state;
    logic [ORDER_W-1:0] order_q;
    logic [31:0]        base_q;
    logic [ORDER_W-1:0] row;
    logic [ORDER_W-1:0] col;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   last_idx;
    logic               tr_q;
    logic [CNT_W-1:0]   lin;
    entry_t             push_entry;
    entry_t             head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_one;
    logic               accept;
    logic               pop;
    logic               is_last_idx;

    assign in_ready    = (state == RUN) && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign pop         = mem_valid && mem_ready;
    assign is_last_idx = (idx == last_idx);

    always_comb begin
        lin = tr_q ? (CNT_W'(col) * CNT_W'(order_q) + CNT_W'(row))
                   : (CNT_W'(row) * CNT_W'(order_q) + CNT_W'(col));
        push_entry.addr = base_q + 32'(lin) * 32'(WORD_BYTES);
        push_entry.data = in_data;
    end

    mat_wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (push_entry),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .one    (fifo_one)
    );

`ifdef MAT_WB_TRANSPOSE_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tr_q <= 1'b0;
        end else if (state == IDLE && start) begin
            tr_q <= transpose;
        end
    end
`else
    assign tr_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            order_q  <= '0;
            base_q   <= '0;
            row      <= '0;
            col      <= '0;
            idx      <= '0;
            last_idx <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        order_q  <= order;
                        base_q   <= base_addr;
                        row      <= '0;
                        col      <= '0;
                        idx      <= '0;
                        last_idx <= CNT_W'(order) * CNT_W'(order) - 1'b1;
                        err      <= 1'b0;
                        state    <= (order == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // Either an early in_last or reaching n*n-1 ends the
                        // matrix; disagreement between the two is the error.
                        if (in_last || is_last_idx) begin
                            state <= FLUSH;
                            if (in_last != is_last_idx) begin
                                err <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                            if (col == order_q - 1'b1) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Leave as soon as the final write handshakes rather
                    // than waiting a further cycle to observe empty.
                    if (fifo_empty || (fifo_one && pop)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The FIFO head drives the port directly: 1-cycle latency from accept,
    // stable under backpressure, and dropped at once by reset.
    assign mem_valid = !fifo_empty;
    assign mem_addr  = mem_valid ? head.addr : '0;
    assign mem_wdata = mem_valid ? head.data : '0;
    assign mem_wstrb = mem_valid ? '1 : '0;
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mat_result_writeback.sv
`timescale 1ns/1ps
module tb_mat_result_writeback;

    localparam int unsigned BITWIDTH   = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ORDER_W    = 10;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                start = 1'b0;
    logic [ORDER_W-1:0]  order = '0;
    logic [31:0]         base_addr = '0;
    logic                tr_in = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                mem_valid;
    logic                mem_ready = 1'b0;
    logic [31:0]         mem_addr;
    logic [BITWIDTH-1:0] mem_wdata;
    logic [3:0]          mem_wstrb;
    logic                busy;
    logic                done;
    logic                err;

    mat_result_writeback #(
        .BITWIDTH   (BITWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ORDER_W    (ORDER_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .order     (order),
        .base_addr (base_addr),
`ifdef MAT_WB_TRANSPOSE_EN
        .transpose (tr_in),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]         addr;
        logic [BITWIDTH-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned last_acc_cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned ready_pct = 100;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic [BITWIDTH-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference address rule: element index i of an n x n row-major stream.
    function automatic logic [31:0] model_addr(input int unsigned n, input logic [31:0] base,
                                               input bit tr, input int unsigned i);
        int unsigned r = i / n;
        int unsigned c = i % n;
        int unsigned lin = tr ? (c * n + r) : (r * n + c);
        return base + 32'(4 * lin);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    always @(negedge resetn) prev_stall = 0;

    // Monitor: pops the scoreboard on every write handshake.
    always @(negedge clk) begin
        wr_t e;
        if (resetn) begin
            if (prev_stall) begin
                chk("stall_valid", mem_valid, 1);
                chk("stall_addr", mem_addr, prev_addr);
                chk("stall_data", mem_wdata, prev_data);
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", mem_wdata, e.data);
                    chk("wr_strb", mem_wstrb, 4'hF);
                end
            end else if (!mem_valid) begin
                chk("idle_strb", mem_wstrb, 4'h0);
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_job(input int unsigned n, input logic [31:0] base, input bit tr);
        @(posedge clk);
        #1;
        start     = 1'b1;
        order     = n[ORDER_W-1:0];
        base_addr = base;
        tr_in     = tr;
        done_cnt  = 0;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // last_at: index carrying in_last (-1 never). Called at posedge+1.
    task automatic feed(input int unsigned n, input int last_at, input int unsigned vpct,
                        input bit tr, input logic [31:0] base, input bit seq);
        int unsigned idx = 0;
        int unsigned guard = 0;
        bit ended = 0;
        acc_cnt = 0;
        while (!ended && guard < 2000) begin
            in_valid = ($urandom_range(0, 99) < vpct);
            in_data  = seq ? BITWIDTH'(idx + 1) : BITWIDTH'($urandom());
            in_last  = (int'(idx) == last_at);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back('{model_addr(n, base, tr, idx), in_data});
                acc_cnt++;
                last_acc_cyc = cyc;
                if (int'(idx) == last_at || idx == n * n - 1) ended = 1;
                idx++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ended) begin
            vectors++;
            miscompares++;
            $display("FAIL feed_timeout: got %0d accepts, expected job end", acc_cnt);
        end
    endtask

    task automatic wait_done(input bit exp_err, input int lat);
        int unsigned g = 0;
        while (done_cnt == 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("err", err, exp_err);
        chk("busy_after", busy, 0);
        chk("writes_left", exp_q.size(), 0);
        if (lat >= 0) chk("done_latency", done_cyc - last_acc_cyc, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit tr;
        int unsigned n;
        logic [31:0] base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic 2x2 at full throughput.
        ready_pct = 100;
        start_job(2, 32'h1000, 0);
        chk("busy_run", busy, 1);
        feed(2, 3, 100, 0, 32'h1000, 1);
        wait_done(0, 2);

        // 3x3 with memory stalled for 10 cycles; a start mid-job is ignored.
        ready_pct = 0;
        @(posedge clk);
        #1;
        start_job(3, 32'h2000, 0);
        fork
            feed(3, 8, 100, 0, 32'h2000, 0);
            begin
                repeat (5) @(negedge clk);
                @(posedge clk);
                #1;
                start = 1'b1;
                order = 1;
                base_addr = 32'h0;
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_accepts", acc_cnt, FIFO_DEPTH);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_mem_valid", mem_valid, 1);
                @(posedge clk);
                #1;
                ready_pct = 100;
            end
        join
        wait_done(0, -1);

        // Early in_last on the 3rd element, memory held off during FLUSH.
        ready_pct = 0;
        start_job(2, 32'h3000, 0);
        feed(2, 2, 100, 0, 32'h3000, 0);
        in_valid = 1'b1;
        start = 1'b1;
        order = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("early_no_accept", in_ready, 0);
        end
        chk("early_err", err, 1);
        chk("early_busy", busy, 1);
        in_valid = 1'b0;
        ready_pct = 100;
        wait_done(1, -1);

        // Missing in_last on the final element.
        start_job(2, 32'h3100, 0);
        feed(2, -1, 100, 0, 32'h3100, 0);
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("miss_no_accept", in_ready, 0);
        end
        in_valid = 1'b0;
        wait_done(1, -1);

        // order == 0: immediate completion, no writes.
        start_job(0, 32'h7000, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_busy", busy, 0);
            chk("zero_mem_valid", mem_valid, 0);
        end
        chk("zero_done_latency", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
        wait_done(0, -1);

`ifdef MAT_WB_TRANSPOSE_EN
        start_job(2, 32'h0, 1);
        feed(2, 3, 100, 1, 32'h0, 1);
        wait_done(0, 2);
`endif

        // Randomized jobs, including a base near the top of the address space.
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 4);
            base = (j == 5) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            tr = 0;
`ifdef MAT_WB_TRANSPOSE_EN
            tr = $urandom_range(0, 1);
`endif
            ready_pct = $urandom_range(30, 100);
            start_job(n, base, tr);
            feed(n, int'(n * n - 1), $urandom_range(50, 100), tr, base, 0);
            wait_done(0, -1);
        end

        // Reset mid-job with a write outstanding, then a clean job.
        ready_pct = 0;
        start_job(3, 32'h4000, 0);
        in_valid = 1'b1;
        repeat (3) begin
            in_data = $urandom();
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_reset_valid", mem_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wdata", mem_wdata, 0);
        chk("mid_rst_mem_wstrb", mem_wstrb, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        ready_pct = 100;
        start_job(2, 32'h5000, 0);
        feed(2, 3, 100, 0, 32'h5000, 0);
        wait_done(0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
